// File: rtl/fixed_point_alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// fixed_point_alu_arbiter_if
//   Bundle of client request/response signals and ALU sequencing signals
//   around the shared fixed-point ALU.
//
//   master modport : the arbiter (drives req_ready, resp_*, alu_start/op/a/b)
//   slave modport  : the environment (clients and ALU)
//
//   Client side : req_valid, req_ready, req_op, req_a, req_b,
//                 resp_valid, resp_result, resp_error
//   ALU side    : alu_start, alu_done, alu_op, alu_a, alu_b, alu_result
// -----------------------------------------------------------------------------
interface fixed_point_alu_arbiter_if #(
  parameter int REQUESTERS   = 2,
  parameter int NUMBER_WIDTH = 16
);
  logic [REQUESTERS-1:0]              req_valid;
  logic [REQUESTERS-1:0]              req_ready;
  logic [3*REQUESTERS-1:0]            req_op;
  logic [NUMBER_WIDTH*REQUESTERS-1:0] req_a;
  logic [NUMBER_WIDTH*REQUESTERS-1:0] req_b;
  logic [REQUESTERS-1:0]              resp_valid;
  logic [NUMBER_WIDTH-1:0]            resp_result;
  logic                               resp_error;
  logic                               alu_start;
  logic                               alu_done;
  logic [2:0]                         alu_op;
  logic [NUMBER_WIDTH-1:0]            alu_a;
  logic [NUMBER_WIDTH-1:0]            alu_b;
  logic [NUMBER_WIDTH-1:0]            alu_result;

  modport master (
    input  req_valid, req_op, req_a, req_b, alu_done, alu_result,
    output req_ready, resp_valid, resp_result, resp_error,
           alu_start, alu_op, alu_a, alu_b
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, alu_done, alu_result,
    input  req_ready, resp_valid, resp_result, resp_error,
           alu_start, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/fixed_point_alu_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_point_alu_arbiter
//   Shares one fixed-point ALU between REQUESTERS clients. One client is
//   granted at a time in round-robin order; its op/a/b are registered onto the
//   ALU inputs, alu_start is pulsed, alu_done is awaited, and the result is
//   returned to the owning client with a one-cycle resp_valid pulse.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-high reset (drops any in-flight operation)
//   bus  : fixed_point_alu_arbiter_if.master
//          req_valid/req_ready/req_op/req_a/req_b  client requests (one-hot ready)
//          resp_valid/resp_result/resp_error       response to owning client
//          alu_start/alu_op/alu_a/alu_b            registered ALU command
//          alu_done/alu_result                     ALU completion
//
// Optional feature (macro FIXED_POINT_ALU_ARBITER_TIMEOUT_EN):
//   When defined, WAIT gives up after TIMEOUT_CYCLES cycles without alu_done
//   and responds with resp_result=0, resp_error=1. When undefined, WAIT waits
//   indefinitely and resp_error is constant 0.
// -----------------------------------------------------------------------------
module fixed_point_alu_arbiter #(
  parameter int REQUESTERS            = 2,
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  fixed_point_alu_arbiter_if.master     bus
);

  localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int PTR_W        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [REQUESTERS-1:0] ONE_HOT0 = REQUESTERS'(1);

  if (REQUESTERS < 1 || REQUESTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fixed_point_alu_arbiter: REQUESTERS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RESPOND} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W-1:0]        cand;
  logic                    found;
  int                      search_idx;

  logic                    accept;
  logic                    done_seen;
  logic                    timeout_hit;

  logic [2:0]              alu_op_r;
  logic [NUMBER_WIDTH-1:0] alu_a_r;
  logic [NUMBER_WIDTH-1:0] alu_b_r;
  logic [NUMBER_WIDTH-1:0] resp_result_r;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    cand       = '0;
    search_idx = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      search_idx = int'(rr_ptr) + k;
      if (search_idx >= REQUESTERS) search_idx = search_idx - REQUESTERS;
      cand = PTR_W'(search_idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef FIXED_POINT_ALU_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            resp_error_r;

  // Counts completed WAIT cycles; the TIMEOUT_CYCLES-th WAIT cycle without
  // alu_done is the last one before RESPOND.
  assign timeout_hit = (state == WAIT) && !bus.alu_done &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == START) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_error_r <= 1'b0;
    end else if (done_seen) begin
      resp_error_r <= 1'b0;
    end else if (timeout_hit) begin
      resp_error_r <= 1'b1;
    end
  end

  assign bus.resp_error = resp_error_r;
`else
  assign timeout_hit    = 1'b0;
  assign bus.resp_error = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.alu_start  = 1'b0;
    bus.resp_valid = '0;
    accept         = 1'b0;
    done_seen      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          bus.req_ready = ONE_HOT0 << winner;
          accept        = 1'b1;
          state_nxt     = START;
        end
      end
      START: begin
        // Any alu_done seen here belongs to a stale operation and is ignored.
        bus.alu_start = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (bus.alu_done) begin
          done_seen = 1'b1;
          state_nxt = RESPOND;
        end else if (timeout_hit) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        bus.resp_valid = ONE_HOT0 << owner;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and registered ALU command / response result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      alu_op_r      <= '0;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      resp_result_r <= '0;
    end else begin
      if (accept) begin
        owner    <= winner;
        alu_op_r <= bus.req_op[int'(winner)*3 +: 3];
        alu_a_r  <= bus.req_a[int'(winner)*NUMBER_WIDTH +: NUMBER_WIDTH];
        alu_b_r  <= bus.req_b[int'(winner)*NUMBER_WIDTH +: NUMBER_WIDTH];
        if (int'(winner) == REQUESTERS - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= winner + PTR_W'(1);
        end
      end
      if (done_seen) begin
        resp_result_r <= bus.alu_result;
      end else if (timeout_hit) begin
        resp_result_r <= '0;
      end
    end
  end

  assign bus.alu_op      = alu_op_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.resp_result = resp_result_r;

endmodule

// File: tb/tb_fixed_point_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_alu_arbiter
//   Directed bench for fixed_point_alu_arbiter (REQUESTERS=2, 8.8 format).
//   The bench plays both clients and the ALU. A vector table covers single
//   requests and round-robin contention; hand-written sequences cover a long
//   ALU stall, done during START, reset in WAIT and (with
//   FIXED_POINT_ALU_ARBITER_TIMEOUT_EN) the WAIT timeout.
// -----------------------------------------------------------------------------
module tb_fixed_point_alu_arbiter;

  localparam int R  = 2;
  localparam int NW = 16;
`ifdef FIXED_POINT_ALU_ARBITER_TIMEOUT_EN
  localparam int STALL = 8;
`else
  localparam int STALL = 20;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_point_alu_arbiter_if #(.REQUESTERS(R), .NUMBER_WIDTH(NW)) bus ();

  fixed_point_alu_arbiter #(
    .REQUESTERS(R), .INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  mask;
    logic [2:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [2:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    int          owner;
    logic [15:0] res;
    int          delay;
  } vec_t;

  vec_t        vecs [6];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_res = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] mask,
                       input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1);
    bus.req_valid = mask;
    bus.req_op    = {op1, op0};
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
  endtask

  // Entered just after a posedge with the arbiter in IDLE and the request
  // applied; returns just after the posedge that leaves RESPOND.
  task automatic do_op(input string tag, input int owner, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input int delay);
    logic [1:0] oh;
    oh = 2'b01 << owner;
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'(oh));
    check({tag, ".resp_idle"}, 32'(bus.resp_valid), 32'h0);
    check({tag, ".result_held"}, 32'(bus.resp_result), 32'(last_res));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".start"}, 32'(bus.alu_start), 32'h1);
    check({tag, ".alu_cmd"}, {13'h0, bus.alu_op, bus.alu_a}, {13'h0, op, a});
    check({tag, ".alu_b"}, 32'(bus.alu_b), 32'(b));
    check({tag, ".ready_busy"}, 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      check({tag, ".wait"}, {29'h0, bus.alu_start, bus.resp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    @(negedge clk);
    check({tag, ".no_early_resp"}, 32'(bus.resp_valid), 32'h0);
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(oh));
    check({tag, ".resp_result"}, 32'(bus.resp_result), 32'(res));
    check({tag, ".resp_error"}, 32'(bus.resp_error), 32'h0);
    last_res = res;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            mask   op0   a0        b0        op1   a1        b1        own res       dly
    vecs[0] = '{2'b01, 3'd1, 16'h0180, 16'h0040, 3'd0, 16'h0000, 16'h0000, 0, 16'h01C0, 3};
    vecs[1] = '{2'b10, 3'd1, 16'h0180, 16'h0040, 3'd2, 16'h0100, 16'h0200, 1, 16'h0300, 2};
    vecs[2] = '{2'b11, 3'd3, 16'h1000, 16'h0010, 3'd4, 16'h2000, 16'h0020, 0, 16'h1010, 2};
    vecs[3] = '{2'b11, 3'd5, 16'h3000, 16'h0030, 3'd4, 16'h2000, 16'h0020, 1, 16'h2020, 1};
    vecs[4] = '{2'b11, 3'd5, 16'h3000, 16'h0030, 3'd6, 16'h4000, 16'h0040, 0, 16'h3030, 4};
    vecs[5] = '{2'b11, 3'd7, 16'hFFFF, 16'h8000, 3'd6, 16'h4000, 16'h0040, 1, 16'hFFFF, 1};

    rst = 1'b1;
    bus.alu_done   = 1'b0;
    bus.alu_result = 16'h0;
    apply(2'b00, 3'd0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.handshake", {28'h0, bus.req_ready, bus.resp_valid}, 32'h0);
    check("reset.start_err", {30'h0, bus.alu_start, bus.resp_error}, 32'h0);
    check("reset.alu_cmd", {13'h0, bus.alu_op, bus.alu_a}, 32'h0);
    check("reset.alu_b", 32'(bus.alu_b), 32'h0);
    check("reset.result", 32'(bus.resp_result), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      apply(vecs[v].mask, vecs[v].op0, vecs[v].a0, vecs[v].b0,
            vecs[v].op1, vecs[v].a1, vecs[v].b1);
      if (vecs[v].owner == 0)
        do_op($sformatf("v%0d", v), 0, vecs[v].op0, vecs[v].a0, vecs[v].b0,
              vecs[v].res, vecs[v].delay);
      else
        do_op($sformatf("v%0d", v), 1, vecs[v].op1, vecs[v].a1, vecs[v].b1,
              vecs[v].res, vecs[v].delay);
    end

    // Long ALU stall on client 1 while client 0 starts requesting.
    apply(2'b10, 3'd1, 16'h1111, 16'h2222, 3'd2, 16'h1234, 16'h5678);
    @(negedge clk);
    check("stall.ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("stall.start", 32'(bus.alu_start), 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < STALL; i++) begin
      @(negedge clk);
      check("stall.ready_low", {28'h0, bus.req_ready, bus.resp_valid}, 32'h0);
      check("stall.operands", {bus.alu_a, bus.alu_b}, 32'h1234_5678);
      @(posedge clk); #1;
    end
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'h0AAA;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    @(negedge clk);
    check("stall.resp_valid", 32'(bus.resp_valid), 32'h2);
    check("stall.resp_result", 32'(bus.resp_result), 32'h0AAA);
    last_res = 16'h0AAA;
    @(posedge clk); #1;
    do_op("after_stall", 0, 3'd1, 16'h1111, 16'h2222, 16'h3333, 2);
    bus.req_valid = 2'b00;

    // alu_done high during START must be ignored.
    apply(2'b01, 3'd3, 16'h0102, 16'h0304, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    check("early.ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid  = 2'b00;
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'hDEAD;
    @(negedge clk);
    check("early.start", 32'(bus.alu_start), 32'h1);
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early.still_wait", 32'(bus.resp_valid), 32'h0);
      check("early.result_held", 32'(bus.resp_result), 32'h3333);
      @(posedge clk); #1;
    end
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'h0BEE;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    @(negedge clk);
    check("early.resp_valid", 32'(bus.resp_valid), 32'h1);
    check("early.resp_result", 32'(bus.resp_result), 32'h0BEE);
    @(posedge clk); #1;

    // Reset asserted in WAIT: outputs clear without a clock edge.
    apply(2'b01, 3'd4, 16'h0A0A, 16'h0B0B, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    check("rstmid.ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.alu_result = 16'h7777;
    #1 rst = 1'b1;
    #1;
    check("rstmid.alu_cmd", {13'h0, bus.alu_op, bus.alu_a}, 32'h0);
    check("rstmid.alu_b", 32'(bus.alu_b), 32'h0);
    check("rstmid.result", {15'h0, bus.resp_error, bus.resp_result}, 32'h0);
    check("rstmid.pulses", {28'h0, bus.resp_valid, bus.alu_start, bus.req_ready[0]}, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.alu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid.no_resp", 32'(bus.resp_valid), 32'h0);
      @(posedge clk); #1;
      bus.alu_done = 1'b0;
    end
    last_res = 16'h0;
    apply(2'b11, 3'd5, 16'h0C0C, 16'h0D0D, 3'd6, 16'h0E0E, 16'h0F0F);
    do_op("after_rst", 0, 3'd5, 16'h0C0C, 16'h0D0D, 16'h1919, 1);
    bus.req_valid = 2'b00;

`ifdef FIXED_POINT_ALU_ARBITER_TIMEOUT_EN
    // No alu_done: response after exactly 10 WAIT cycles, with error.
    apply(2'b10, 3'd0, 16'h0, 16'h0, 3'd7, 16'h0E0E, 16'h0F0F);
    @(negedge clk);
    check("timeout.ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("timeout.start", 32'(bus.alu_start), 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("timeout.waiting", 32'(bus.resp_valid), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("timeout.resp_valid", 32'(bus.resp_valid), 32'h2);
    check("timeout.resp_error", 32'(bus.resp_error), 32'h1);
    check("timeout.resp_result", 32'(bus.resp_result), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("timeout.error_held", {30'h0, bus.resp_error, bus.resp_valid[1]}, 32'h2);
    last_res = 16'h0;
    apply(2'b01, 3'd2, 16'h0505, 16'h0606, 3'd0, 16'h0, 16'h0);
    do_op("after_timeout", 0, 3'd2, 16'h0505, 16'h0606, 16'h0B0B, 2);
    bus.req_valid = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
